// File: rtl/otter_iobus_timer.sv
// otter_iobus_timer: memory-mapped programmable down-counter timer on the OTTER IOBUS.
// Registers in a 16-byte window at BASE_ADDR:
//   0x0 CTRL   [0] EN, [1] AUTO, [2] IE, [PRESC_W+7:8] PRESC
//   0x4 LOAD   reload value
//   0x8 COUNT  current count (read-only)
//   0xC STATUS [0] EXP, write-1-to-clear
// Read data is registered, so it arrives one cycle after the address.
// Optional build macro OTMR_PULSE_INTR_EN: INTR becomes a fixed-width pulse
// of INTR_PULSE_CYCLES cycles on each rise of (EXP & IE) instead of a level.

module otter_iobus_timer #(
   parameter logic [31:0] BASE_ADDR         = 32'h1100_0200,
   parameter int          PRESC_W           = 8,
   parameter int          INTR_PULSE_CYCLES = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] IO_RD_DATA,
   output logic        INTR
);

   typedef enum logic [1:0] {
      OFF_CTRL   = 2'd0,
      OFF_LOAD   = 2'd1,
      OFF_COUNT  = 2'd2,
      OFF_STATUS = 2'd3
   } reg_off_t;

   // architectural state
   logic               en, auto_rl, ie, exp_flag;
   logic [PRESC_W-1:0] presc, presc_cnt;
   logic [31:0]        load_val, count;

   // next-state values
   logic               en_n, auto_rl_n, ie_n, exp_flag_n;
   logic [PRESC_W-1:0] presc_n, presc_cnt_n;
   logic [31:0]        load_val_n, count_n, rd_data_n, ctrl_word;

   logic     hit, wr_hit, tick;
   reg_off_t off;

   // byte lanes are not decoded; every access is a full word
   logic unused_addr_bits;
   assign unused_addr_bits = ^IOBUS_ADDR[1:0];

   assign hit    = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
   assign off    = reg_off_t'(IOBUS_ADDR[3:2]);
   assign wr_hit = IOBUS_WR && hit;
   assign tick   = en && (presc_cnt == presc);

   // next-state logic: counting first, then bus writes so a CTRL write overrides expiry
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      en_n        = en;
      auto_rl_n   = auto_rl;
      ie_n        = ie;
      presc_n     = presc;
      load_val_n  = load_val;
      count_n     = count;
      presc_cnt_n = presc_cnt;
      exp_flag_n  = exp_flag;

      if (en) presc_cnt_n = tick ? '0 : presc_cnt + 1'b1;

      if (tick) begin
         if (count != 32'd0) begin
            count_n = count - 1'b1;
         end else if (auto_rl) begin
            count_n = load_val;   // old LOAD even if LOAD is written this cycle
         end else begin
            en_n = 1'b0;
         end
      end

      if (wr_hit) begin
         case (off)
            OFF_CTRL: begin
               en_n      = IOBUS_OUT[0];
               auto_rl_n = IOBUS_OUT[1];
               ie_n      = IOBUS_OUT[2];
               presc_n   = IOBUS_OUT[PRESC_W+7:8];
               if (!en && IOBUS_OUT[0]) begin
                  count_n     = load_val;
                  presc_cnt_n = '0;
               end
            end
            OFF_LOAD:   load_val_n = IOBUS_OUT;
            OFF_STATUS: if (IOBUS_OUT[0]) exp_flag_n = 1'b0;
            default: ;
         endcase
      end

      // expiry sets EXP after the clear so a same-cycle set wins
      if (tick && count == 32'd0) exp_flag_n = 1'b1;
   end

   // read mux from current register values
   always_comb begin
      ctrl_word                = '0;
      ctrl_word[2:0]           = {ie, auto_rl, en};
      ctrl_word[PRESC_W+7:8]   = presc;
      rd_data_n                = '0;
      if (hit) begin
         case (off)
            OFF_CTRL:   rd_data_n = ctrl_word;
            OFF_LOAD:   rd_data_n = load_val;
            OFF_COUNT:  rd_data_n = count;
            OFF_STATUS: rd_data_n = {31'd0, exp_flag};
            default:    rd_data_n = '0;
         endcase
      end
   end

`ifdef OTMR_PULSE_INTR_EN
   logic [3:0] pulse_cnt, pulse_cnt_n;
   logic       intr_rise;

   assign intr_rise = (exp_flag_n && ie_n) && !(exp_flag && ie);

   // pulse length counter, restarted by every rise of EXP & IE
   always_comb begin
      pulse_cnt_n = (pulse_cnt != 4'd0) ? pulse_cnt - 1'b1 : 4'd0;
      if (intr_rise) pulse_cnt_n = 4'(INTR_PULSE_CYCLES);
   end

   // pulse counter and registered INTR
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pulse_cnt <= '0;
         INTR      <= 1'b0;
      end else begin
         pulse_cnt <= pulse_cnt_n;
         INTR      <= (pulse_cnt_n != 4'd0);
      end
   end
`else
   // level interrupt: follows the next EXP qualified by IE
   always_ff @(posedge CLK) begin
      if (RESET) INTR <= 1'b0;
      else       INTR <= exp_flag_n && ie_n;
   end
`endif

   // register state and registered read data
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (RESET) begin
         en         <= 1'b0;
         auto_rl    <= 1'b0;
         ie         <= 1'b0;
         presc      <= '0;
         load_val   <= '0;
         count      <= '0;
         presc_cnt  <= '0;
         exp_flag   <= 1'b0;
         IO_RD_DATA <= '0;
      end else begin
         en         <= en_n;
         auto_rl    <= auto_rl_n;
         ie         <= ie_n;
         presc      <= presc_n;
         load_val   <= load_val_n;
         count      <= count_n;
         presc_cnt  <= presc_cnt_n;
         exp_flag   <= exp_flag_n;
         IO_RD_DATA <= rd_data_n;
      end
   end

endmodule
